// File: rtl/sqrt_iter_param_pkg.sv
// Shared FSM state encoding and width helpers for the iterative square-root unit.
package sqrt_iter_param_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter holds N-1, so clog2(N) bits suffice; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_iter_param_step.sv
// One restoring square-root iteration: shift in a radicand bit pair, trial-subtract, emit a root bit.
module sqrt_iter_param_step #(
  parameter int RW = 4
) (
  input  logic [RW+1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    pair,
  output logic [RW+1:0] rem_out,
  output logic [RW-1:0] root_out,
  output logic          ge
);

  // Full-width shift and trial so the compare stays exact even when reused for the guard.
  logic [RW+3:0] w_rem_sh;
  logic [RW+3:0] w_trial;
  logic [RW+3:0] w_diff;
  logic [RW:0]   w_root_sh;
  logic          w_unused;

  assign w_rem_sh  = {rem_in, pair};
  assign w_trial   = {2'b00, root_in, 2'b01};
  assign ge        = (w_rem_sh >= w_trial);
  assign w_diff    = ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_sh = {root_in, ge};
  assign rem_out   = w_diff[RW+1:0];
  assign root_out  = w_root_sh[RW-1:0];
  assign w_unused  = ^{w_diff[RW+3:RW+2], w_root_sh[RW]};

endmodule

// File: rtl/sqrt_iter_param.sv
// Sequential digit-by-digit square root, one result bit per clock, Start/Done handshake.
// Define SQRT_ROUND_EN for an extra ROUND cycle that rounds Result to nearest (saturating).
module sqrt_iter_param
  import sqrt_iter_param_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int FRAC_BITS = 0,
  localparam int RES_W     = WIDTH / 2 + FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  output logic [RES_W-1:0] Result,
  output logic [RES_W:0]   Remainder,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = RES_W;
  localparam int EXT_W = 2 * RES_W;
  localparam int CNT_W = cnt_w(N);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("sqrt_iter_param: WIDTH must be even and >= 2");
  end

  state_t           r_state;
  logic [EXT_W-1:0] r_rad;
  logic [RES_W+1:0] r_rem;
  logic [RES_W-1:0] r_root;
  logic [CNT_W-1:0] r_cnt;

  logic [RES_W+1:0] w_rem;
  logic [RES_W-1:0] w_root;
  logic             w_ge_unused;

  sqrt_iter_param_step #(.RW(RES_W)) u_step (
    .rem_in  (r_rem),
    .root_in (r_root),
    .pair    (r_rad[EXT_W-1 -: 2]),
    .rem_out (w_rem),
    .root_out(w_root),
    .ge      (w_ge_unused)
  );

`ifdef SQRT_ROUND_EN
  // Guard = one more iteration with a zero pair: does the next root bit come out 1?
  logic             w_guard;
  logic [RES_W+1:0] w_g_rem_unused;
  logic [RES_W-1:0] w_g_root_unused;

  sqrt_iter_param_step #(.RW(RES_W)) u_guard (
    .rem_in  (r_rem),
    .root_in (r_root),
    .pair    (2'b00),
    .rem_out (w_g_rem_unused),
    .root_out(w_g_root_unused),
    .ge      (w_guard)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rad     <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_cnt     <= '0;
      Result    <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_rad   <= EXT_W'(A) << (2 * FRAC_BITS);
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= CNT_W'(N - 1);
            Busy    <= 1'b1;
            Done    <= 1'b0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem;
          r_root <= w_root;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
`ifdef SQRT_ROUND_EN
            r_state <= S_ROUND;
`else
            Result    <= w_root;
            Remainder <= w_rem[RES_W:0];
            Busy      <= 1'b0;
            Done      <= 1'b1;
            r_state   <= S_DONE;
`endif
          end
        end
`ifdef SQRT_ROUND_EN
        S_ROUND: begin
          Result    <= (&r_root) ? r_root : r_root + RES_W'(w_guard);
          Remainder <= r_rem[RES_W:0];
          Busy      <= 1'b0;
          Done      <= 1'b1;
          r_state   <= S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_param.sv
// Directed + randomized bench for sqrt_iter_param over three parameter sets.
module tb_sqrt_iter_param;

`ifdef SQRT_ROUND_EN
  localparam int LAT_ADD = 1;
`else
  localparam int LAT_ADD = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // k=0: WIDTH 8 / FRAC 0, k=1: WIDTH 8 / FRAC 4, k=2: WIDTH 16 / FRAC 0
  logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [7:0]  a0 = '0, a1 = '0;
  logic [15:0] a2 = '0;
  logic [3:0]  r0;
  logic [4:0]  m0;
  logic [7:0]  r1, r2;
  logic [8:0]  m1, m2;
  logic        b0, b1, b2, d0, d1, d2;

  sqrt_iter_param #(.WIDTH(8), .FRAC_BITS(0)) u_d8 (
    .clk(clk), .reset(reset), .Start(s0), .A(a0),
    .Result(r0), .Remainder(m0), .Busy(b0), .Done(d0));
  sqrt_iter_param #(.WIDTH(8), .FRAC_BITS(4)) u_f8 (
    .clk(clk), .reset(reset), .Start(s1), .A(a1),
    .Result(r1), .Remainder(m1), .Busy(b1), .Done(d1));
  sqrt_iter_param #(.WIDTH(16), .FRAC_BITS(0)) u_d16 (
    .clk(clk), .reset(reset), .Start(s2), .A(a2),
    .Result(r2), .Remainder(m2), .Busy(b2), .Done(d2));

  int n_checks = 0;
  int n_fail   = 0;
  int exp_res [3];
  int exp_rem [3];
  bit armed   [3] = '{0, 0, 0};

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, found by search rather than bit iteration.
  function automatic void model(input longint x, input int resw, output int res, output int rem);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    rem = int'(x - r * r);
    res = int'(r);
`ifdef SQRT_ROUND_EN
    if (x - r * r > r) res = (r + 1 > (1 << resw) - 1) ? ((1 << resw) - 1) : int'(r + 1);
`endif
  endfunction

  function automatic int frac_of(input int k);  return (k == 1) ? 4 : 0; endfunction
  function automatic int resw_of(input int k);  return (k == 0) ? 4 : 8; endfunction
  function automatic int lat_of(input int k);   return resw_of(k) + LAT_ADD; endfunction
  function automatic bit done_of(input int k);  return (k == 0) ? d0 : (k == 1) ? d1 : d2; endfunction
  function automatic bit busy_of(input int k);  return (k == 0) ? b0 : (k == 1) ? b1 : b2; endfunction

  task automatic drive(input int k, input int a, input bit s);
    case (k)
      0: begin a0 = a[7:0];  s0 = s; end
      1: begin a1 = a[7:0];  s1 = s; end
      default: begin a2 = a[15:0]; s2 = s; end
    endcase
  endtask

  // Single compare process: whenever an armed DUT shows Done, its outputs must match the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (armed[0] && d0) begin check("d8_result", r0, exp_res[0]);  check("d8_remainder", m0, exp_rem[0]);  end
      if (armed[1] && d1) begin check("f8_result", r1, exp_res[1]);  check("f8_remainder", m1, exp_rem[1]);  end
      if (armed[2] && d2) begin check("d16_result", r2, exp_res[2]); check("d16_remainder", m2, exp_rem[2]); end
    end
  end

  // glitch >= 0: pulse Start (with a different A) for one edge that many cycles into CALC.
  task automatic start_op(input int k, input int a, input int glitch);
    int cyc;
    bit fin;
    @(negedge clk);
    armed[k] = 1'b0;
    drive(k, a, 1'b1);
    @(posedge clk); #1;
    drive(k, a, 1'b0);
    check("accept_done_low", done_of(k), 0);
    check("accept_busy_high", busy_of(k), 1);
    model(longint'(a) << (2 * frac_of(k)), resw_of(k), exp_res[k], exp_rem[k]);
    armed[k] = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 40) begin
      if (cyc == glitch) drive(k, a ^ 5, 1'b1);
      @(posedge clk); #1;
      if (cyc == glitch) drive(k, a ^ 5, 1'b0);
      cyc++;
      fin = done_of(k);
    end
    check("latency", cyc, lat_of(k));
    @(negedge clk);
  endtask

  initial begin
    int res, rem;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, rem;

    // Hand-computed pins on the model itself
    model(144, 4, res, rem);       check("model_144_res", res, 12); check("model_144_rem", rem, 0);
    model(2 << 8, 8, res, rem);    check("model_frac2_rem", rem, 28);
    model(65535, 8, res, rem);     check("model_65535_res", res, 255); check("model_65535_rem", rem, 510);
    model(255, 4, res, rem);       check("model_255_res", res, 15); check("model_255_rem", rem, 30);
`ifdef SQRT_ROUND_EN
    model(2 << 8, 8, res, rem);    check("model_frac2_res", res, 23);
`else
    model(2 << 8, 8, res, rem);    check("model_frac2_res", res, 22);
    model(200, 4, res, rem);       check("model_200_res", res, 14); check("model_200_rem", rem, 4);
`endif

    // Reset state
    #13;
    check("rst_result", r0, 0); check("rst_remainder", m0, 0);
    check("rst_busy", b0, 0);   check("rst_done", d0, 0);
    check("rst_d16_done", d2, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    start_op(0, 144, -1);
    check("lit_144_result", r0, 12); check("lit_144_remainder", m0, 0);
    start_op(0, 200, -1);
    start_op(0, 255, -1);
    check("lit_255_result", r0, 15); check("lit_255_remainder", m0, 30);
    start_op(0, 0, -1);
    check("lit_0_result", r0, 0); check("lit_0_remainder", m0, 0);
    start_op(0, 1, -1);
    start_op(1, 2, -1);
    check("lit_frac2_result", r1, 22 + LAT_ADD); check("lit_frac2_remainder", m1, 28);
    start_op(1, 255, -1);
    start_op(1, 0, -1);
    start_op(2, 65535, -1);
    check("lit_65535_result", r2, 255); check("lit_65535_remainder", m2, 510);
    start_op(2, 0, -1);
    start_op(2, 40000, -1);

    // Start pulsed mid-CALC must be ignored
    start_op(0, 200, 1);
    check("glitch_result", r0, 14);
    start_op(2, 12345, 3);

    // Asynchronous reset between edges, mid-CALC
    @(negedge clk);
    armed[0] = 1'b0;
    a0 = 8'd255; s0 = 1'b1;
    @(posedge clk); #1;
    s0 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_result", r0, 0); check("arst_remainder", m0, 0);
    check("arst_busy", b0, 0);   check("arst_done", d0, 0);
    @(negedge clk);
    reset = 1'b0;
    start_op(0, 144, -1);

    // Randomized sweep, 1000 operations across the three configurations
    for (int i = 0; i < 400; i++) start_op(0, int'($urandom_range(0, 255)), -1);
    for (int i = 0; i < 300; i++) start_op(1, int'($urandom_range(0, 255)), -1);
    for (int i = 0; i < 300; i++) start_op(2, int'($urandom_range(0, 65535)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
